// File: rtl/fpu_arbiter.sv
// Shares one fpu between N clients: round-robin grant, one operation in flight,
// issue/wait/respond handshake sequencing with a watchdog that fabricates an error result.
module fpu_arbiter #(
  parameter int bitness    = 32,
  parameter int requesters = 4,
  parameter int timeout    = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [requesters-1:0]         req_valid,
  output logic [requesters-1:0]         req_ack,
  input  logic [requesters*bitness-1:0] req_data_a,
  input  logic [requesters*bitness-1:0] req_data_b,
  input  logic [requesters*4-1:0]       req_operation,
  output logic [requesters-1:0]         resp_rdy,
  input  logic [requesters-1:0]         resp_ack,
  output logic [bitness-1:0]            resp_result,
  output logic                          resp_error,
  output logic                          error,
  output logic                          fpu_input_rdy,
  input  logic                          fpu_input_ack,
  output logic [bitness-1:0]            fpu_data_a,
  output logic [bitness-1:0]            fpu_data_b,
  output logic [3:0]                    fpu_operation,
  input  logic                          fpu_output_rdy,
  output logic                          fpu_output_ack,
  input  logic [bitness-1:0]            fpu_result
);

  localparam int gw = (requesters > 1) ? $clog2(requesters) : 1;
  localparam int cw = $clog2(timeout + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [gw-1:0]         rr_q, rr_d;
  logic [gw-1:0]         grant_q, grant_d;
  logic [cw-1:0]         wd_cnt_q, wd_cnt_d;
  logic [requesters-1:0] req_ack_q, req_ack_d;
  logic [requesters-1:0] resp_rdy_q, resp_rdy_d;
  logic [bitness-1:0]    resp_result_q, resp_result_d;
  logic                  resp_error_q, resp_error_d;
  logic                  error_q, error_d;
  logic                  fpu_input_rdy_q, fpu_input_rdy_d;
  logic                  fpu_output_ack_q, fpu_output_ack_d;
  logic [bitness-1:0]    fpu_data_a_q, fpu_data_a_d;
  logic [bitness-1:0]    fpu_data_b_q, fpu_data_b_d;
  logic [3:0]            fpu_operation_q, fpu_operation_d;

  // The fpu's input_ack is informational only; sequencing relies on input_rdy timing.
  logic unused_fpu_input_ack;
  assign unused_fpu_input_ack = fpu_input_ack;

  // Round-robin pick: first requester at or above rr_q, else the lowest one (wrap).
  logic          pick_vld;
  logic          hi_vld;
  logic [gw-1:0] hi_idx;
  logic [gw-1:0] lo_idx;
  logic [gw-1:0] pick_idx;

  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = requesters - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_idx = gw'(i);
        if (gw'(i) >= rr_q) begin
          hi_vld = 1'b1;
          hi_idx = gw'(i);
        end
      end
    end
    pick_vld = |req_valid;
    pick_idx = hi_vld ? hi_idx : lo_idx;
  end

  logic [requesters-1:0] pick_oh;
  logic [requesters-1:0] grant_oh;
  logic [bitness-1:0]    sel_a;
  logic [bitness-1:0]    sel_b;
  logic [3:0]            sel_op;

  always_comb begin
    pick_oh  = '0;
    grant_oh = '0;
    sel_a    = '0;
    sel_b    = '0;
    sel_op   = '0;
    for (int i = 0; i < requesters; i++) begin
      pick_oh[i]  = (pick_idx == gw'(i));
      grant_oh[i] = (grant_q == gw'(i));
      if (pick_idx == gw'(i)) begin
        sel_a  = req_data_a[i*bitness +: bitness];
        sel_b  = req_data_b[i*bitness +: bitness];
        sel_op = req_operation[i*4 +: 4];
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    rr_d             = rr_q;
    grant_d          = grant_q;
    wd_cnt_d         = wd_cnt_q;
    req_ack_d        = '0;
    resp_rdy_d       = resp_rdy_q;
    resp_result_d    = resp_result_q;
    resp_error_d     = resp_error_q;
    error_d          = error_q;
    fpu_input_rdy_d  = 1'b0;
    fpu_output_ack_d = 1'b0;
    fpu_data_a_d     = fpu_data_a_q;
    fpu_data_b_d     = fpu_data_b_q;
    fpu_operation_d  = fpu_operation_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d         = pick_idx;
          fpu_data_a_d    = sel_a;
          fpu_data_b_d    = sel_b;
          fpu_operation_d = sel_op;
          req_ack_d       = pick_oh;
          fpu_input_rdy_d = 1'b1;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        wd_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        if (fpu_output_rdy) begin
          resp_result_d    = fpu_result;
          resp_error_d     = 1'b0;
          fpu_output_ack_d = 1'b1;
          resp_rdy_d       = grant_oh;
          state_d          = RESP;
        end else if (wd_cnt_q == cw'(timeout - 1)) begin
          // Hung fpu: answer the client with an all-ones error result, no output_ack.
          resp_result_d = '1;
          resp_error_d  = 1'b1;
          error_d       = 1'b1;
          resp_rdy_d    = grant_oh;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (|(resp_ack & grant_oh)) begin
          resp_rdy_d   = '0;
          resp_error_d = 1'b0;
          rr_d         = (grant_q == gw'(requesters - 1)) ? '0 : grant_q + 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      rr_q             <= '0;
      grant_q          <= '0;
      wd_cnt_q         <= '0;
      req_ack_q        <= '0;
      resp_rdy_q       <= '0;
      resp_result_q    <= '0;
      resp_error_q     <= 1'b0;
      error_q          <= 1'b0;
      fpu_input_rdy_q  <= 1'b0;
      fpu_output_ack_q <= 1'b0;
      fpu_data_a_q     <= '0;
      fpu_data_b_q     <= '0;
      fpu_operation_q  <= '0;
    end else begin
      state_q          <= state_d;
      rr_q             <= rr_d;
      grant_q          <= grant_d;
      wd_cnt_q         <= wd_cnt_d;
      req_ack_q        <= req_ack_d;
      resp_rdy_q       <= resp_rdy_d;
      resp_result_q    <= resp_result_d;
      resp_error_q     <= resp_error_d;
      error_q          <= error_d;
      fpu_input_rdy_q  <= fpu_input_rdy_d;
      fpu_output_ack_q <= fpu_output_ack_d;
      fpu_data_a_q     <= fpu_data_a_d;
      fpu_data_b_q     <= fpu_data_b_d;
      fpu_operation_q  <= fpu_operation_d;
    end
  end

  assign req_ack        = req_ack_q;
  assign resp_rdy       = resp_rdy_q;
  assign resp_result    = resp_result_q;
  assign resp_error     = resp_error_q;
  assign error          = error_q;
  assign fpu_input_rdy  = fpu_input_rdy_q;
  assign fpu_output_ack = fpu_output_ack_q;
  assign fpu_data_a     = fpu_data_a_q;
  assign fpu_data_b     = fpu_data_b_q;
  assign fpu_operation  = fpu_operation_q;

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares one fpu instance between N requesters.
- Round-robin grant, with one operation outstanding at a time.
- Sequences the fpu handshakes: input_rdy pulse, wait for output_rdy, output_ack pulse.
- Returns the result to the granted requester, with a watchdog on a hung fpu.
- Sits between client pipelines and the fpu datapath; both share clock and reset.

Parameters:
- bitness, 32: operand/result width; passed through to the fpu.
- requesters, 4: number of clients, 2..16; gw = $clog2(requesters).
- timeout, 64: maximum cycles in WAIT before an error is declared; counter width $clog2(timeout+1).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  requesters  per-client operation request; held until acknowledged.
- req_ack  out  requesters  one-cycle pulse: request accepted, operands captured.
- req_data_a  in  requesters*bitness  client i operand A at [i*bitness +: bitness].
- req_data_b  in  requesters*bitness  client i operand B, same slicing.
- req_operation  in  requesters*4  client i Word_t at [i*4 +: 4].
- resp_rdy  out  requesters  result valid for client i; held until resp_ack[i].
- resp_ack  in  requesters  client i consumes the result.
- resp_result  out  bitness  result for the client whose resp_rdy is high.
- resp_error  out  1  high with resp_rdy when the result came from a timeout.
- error  out  1  sticky watchdog flag; cleared only by reset.
- fpu_input_rdy  out  1  to fpu input_rdy.
- fpu_input_ack  in  1  from fpu input_ack; monitored only.
- fpu_data_a  out  bitness  to fpu data_a.
- fpu_data_b  out  bitness  to fpu data_b.
- fpu_operation  out  4  to fpu operation.
- fpu_output_rdy  in  1  from fpu output_rdy.
- fpu_output_ack  out  1  to fpu output_ack.
- fpu_result  in  bitness  from fpu result.

Behaviour:
- Reset:
  - state IDLE, rr pointer 0, all registers 0.
  - All outputs 0: req_ack, resp_rdy, resp_result, resp_error, error, fpu_input_rdy, fpu_output_ack, fpu_data_a/b, fpu_operation.
  - Reset asserted in any state aborts the operation with no pulses emitted. The fpu shares the reset, so both sides restart clean.
- All outputs are registered. FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant g = first set bit scanning from rr pointer upward with wrap.
  - Latch the slices of g into fpu_data_a, fpu_data_b and fpu_operation; store g.
  - Next cycle: req_ack[g]=1 for exactly one cycle, fpu_input_rdy=1, state ISSUE.
  - Lower-priority simultaneous requests stay pending; their req_ack stays 0.
- ISSUE (one cycle):
  - fpu_input_rdy is high this cycle only, then drops.
  - fpu_data_* are held until the next grant.
  - Watchdog counter cleared; next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - If fpu_output_rdy: latch fpu_result into resp_result, pulse fpu_output_ack for one cycle, resp_error=0, state RESP.
  - Else if counter == timeout-1: resp_result = all ones, resp_error=1, error=1 (sticky), no fpu_output_ack, state RESP.
- RESP:
  - resp_rdy[g]=1 and resp_result stable until resp_ack[g] is sampled high.
  - That same cycle resp_rdy clears, rr pointer = g+1 (wraps to 0 at requesters), state IDLE.
  - resp_ack on bits other than g is ignored.
- Latencies:
  - req_valid sampled at t: req_ack and fpu_input_rdy at t+1, WAIT from t+2.
  - fpu_output_rdy seen at cycle w: resp_rdy at w+1.
  - After resp_ack: IDLE the next cycle; at least 2 cycles between fpu_output_ack and the next fpu_input_rdy, so the fpu is back waiting for input.
- fpu_input_ack may stay high across transactions; it does not gate the FSM.
- A client that drops req_valid before req_ack simply loses eligibility; no partial capture.
- Only one resp_rdy bit and at most one req_ack bit are ever high.
- After error is set, arbitration continues normally.

Test Plan:
- Single op:
  - Stimulus: client 0 requests add, A=0x3F800000 (1.0), B=0x40000000 (2.0); fpu model answers 0x40400000 after 5 cycles.
  - Response: req_ack[0] at t+1; fpu_input_rdy high 1 cycle; resp_rdy[0] with 0x40400000; resp_error=0.
- Round-robin:
  - Stimulus: clients 0, 1 and 3 assert req_valid together and hold.
  - Response: grant order 0, 1, 3, then 0 again if re-requested; exactly one req_ack per grant.
- Backpressure:
  - Stimulus: client 2 withholds resp_ack for 10 cycles.
  - Response: resp_rdy[2] and resp_result stable throughout; no new fpu_input_rdy until 2 cycles after the ack.
- Timeout:
  - Stimulus: fpu model never raises output_rdy, timeout=64.
  - Response: resp_rdy at cycle 65 after ISSUE, resp_result=0xFFFFFFFF, resp_error=1, error stays 1; the next request is still served.
- Reset mid-WAIT:
  - Stimulus: assert reset for 1 cycle during WAIT.
  - Response: all outputs 0 next cycle; a pending client is re-granted from rr pointer 0 after reset.
- Spurious ack:
  - Stimulus: resp_ack[1] held high while client 0 owns RESP.
  - Response: ignored; resp_rdy[0] stays high until resp_ack[0].
